reg_file_scoreboard: RTL and testbench
======================================

# reg_file_scoreboard

Parametrised successor to the core's integer register file: configurable data width, register count and number of read ports, a same-cycle write-to-read bypass, and a per-register busy scoreboard. The decode stage uses the scoreboard to detect RAW and WAW hazards against in-flight producers. It sits between decode (reads, issue) and writeback (write port) of the in-order RISC-V pipeline. Register 0 is hardwired to zero.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NUM_REGS, 32, register count; power of two, ≥2
- NUM_RD, 2, number of read ports, 1..4
- BYPASS, 1, 1 = writeback value forwarded combinationally to matching reads; 0 = no forwarding
- AW, derived $clog2(NUM_REGS), address width (localparam)

Ports:
- SYS_clk  input  1  clock; all state updates on rising edge
- SYS_reset  input  1  synchronous, active-high reset
- REG_rd_addr  input  NUM_RD*AW  read addresses, port k at [k*AW +: AW]
- REG_rd_used  input  NUM_RD  port k's operand is actually consumed by the decoding instruction
- REG_rd_data  output  NUM_RD*XLEN  read data, port k at [k*XLEN +: XLEN]
- REG_rd_busy  output  NUM_RD  port k's register has an outstanding producer
- REG_write_enable  input  1  writeback valid
- REG_write_address  input  AW  writeback destination
- REG_write_value  input  XLEN  writeback data
- REG_issue_enable  input  1  decode requests to issue an instruction writing REG_issue_address
- REG_issue_address  input  AW  destination of issuing instruction
- REG_stall  output  1  issue request refused this cycle

## Operation
- Storage: NUM_REGS × XLEN array; entry 0 always reads 0 and is never written.
- Write: if REG_write_enable and address ≠ 0, entry updated at the edge.
- Read (combinational): address 0 → 0. If BYPASS=1, REG_write_enable and address matches (≠0) → REG_write_value. Otherwise → array entry.
- Busy vector: one bit per register; bit 0 is constant 0.
- Writeback with address ≠ 0 clears busy[address] at the edge.
- Accepted issue (REG_issue_enable=1, REG_stall=0, address ≠ 0) sets busy[address] at the edge.
- Same-register writeback and accepted issue in one cycle: busy stays 1 (new producer); the value is still written.
- REG_rd_busy[k] = busy[addr_k], except 0 when BYPASS=1 and this cycle's writeback targets addr_k.
- REG_stall = REG_issue_enable AND (any k with REG_rd_used[k] & REG_rd_busy[k], OR WAW: busy[issue_address] set and not cleared by this cycle's writeback under BYPASS=1).
- Stall with issue_enable=0 is always 0. A refused issue sets no busy bit.
- Reset: all entries 0, all busy bits 0. Reset overrides same-cycle write and issue.
- Outputs during/after reset: REG_rd_data 0, REG_rd_busy 0, REG_stall 0.

## Timing
- Read latency 0 (combinational from addresses, array and write port).
- Write visible via array one cycle after REG_write_enable; same cycle via bypass when BYPASS=1.
- Busy set is visible the cycle after an accepted issue.
- Busy clear is visible the cycle after writeback. With BYPASS=1 it is masked in the writeback cycle itself.
- BYPASS=0: a read matching the current writeback returns the old value with busy=1, so the consumer stalls one extra cycle.
- Reset mid-operation drops all pending producers. Writebacks arriving after reset still write data; clearing an already-clear busy bit is harmless.

## Structure
- Package regfile_pkg: default XLEN/NUM_REGS/NUM_RD constants, zero-register index constant.
- Sub-module reg_scoreboard: busy vector, set/clear/priority logic and reset. Inputs: issue/write handshakes. Outputs: busy vector.
- Top module holds data array, read muxes, bypass, and stall combine.
- Read ports are generated with a generate loop over NUM_RD.

## Test plan
- Reset: write 0xDEADBEEF to x5 in the same cycle as SYS_reset=1 → next cycle x5 reads 0, all busy 0.
- x0: write 0x1234 to x0, issue to x0 → x0 reads 0, busy[0] stays 0, REG_stall=0.
- RAW with bypass: issue x7, then port 0 reads x7 with used=1 → stall=1. Writeback 0xA5A5A5A5 to x7 → same cycle data=0xA5A5A5A5, busy=0, stall=0. Repeat with BYPASS=0 → stall persists one more cycle, then x7 reads 0xA5A5A5A5.
- Simultaneous writeback + issue on x9 (BYPASS=1): busy[9]=1 next cycle, value written. A later read of x9 (used=1) stalls until the second writeback.
- WAW and used mask: x3 busy, issue to x3 → stall=1, no busy change. Read x3 on port 1 with used[1]=0 and no WAW → stall=0.
- Parametrised instance XLEN=64, NUM_REGS=16, NUM_RD=3: write 0xFFFF_0000_FFFF_0000 to x15 → all three ports read it when addressed 15. Address 0 reads 0 on all ports.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults for the parametrised integer register file and its busy scoreboard.
package regfile_pkg;

  localparam int DEFAULT_XLEN     = 32;
  localparam int DEFAULT_NUM_REGS = 32;
  localparam int DEFAULT_NUM_RD   = 2;
  localparam int ZERO_REG         = 0;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy vector: issue marks a destination as having an in-flight producer,
// writeback retires it. A same-cycle issue wins because it names a newer producer.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                SYS_clk,
  input  logic                SYS_reset,
  input  logic                issue_accept,
  input  logic [AW-1:0]       issue_address,
  input  logic                write_enable,
  input  logic [AW-1:0]       write_address,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_next;

  always_comb begin
    busy_next = busy;
    if (write_enable && write_address != AW'(ZERO_REG))
      busy_next[write_address] = 1'b0;
    if (issue_accept && issue_address != AW'(ZERO_REG))
      busy_next[issue_address] = 1'b1;
    busy_next[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset)
      busy <= '0;
    else
      busy <= busy_next;
  end

endmodule

// File: rtl/reg_file_scoreboard.sv
// Integer register file with optional writeback bypass and a busy scoreboard that
// lets decode refuse issue on RAW (used operands) and WAW (busy destination) hazards.
module reg_file_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN     = DEFAULT_XLEN,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int NUM_RD   = DEFAULT_NUM_RD,
  parameter int BYPASS   = 1
) (
  input  logic                     SYS_clk,
  input  logic                     SYS_reset,
  input  logic [NUM_RD*$clog2(NUM_REGS)-1:0] REG_rd_addr,
  input  logic [NUM_RD-1:0]        REG_rd_used,
  output logic [NUM_RD*XLEN-1:0]   REG_rd_data,
  output logic [NUM_RD-1:0]        REG_rd_busy,
  input  logic                     REG_write_enable,
  input  logic [$clog2(NUM_REGS)-1:0] REG_write_address,
  input  logic [XLEN-1:0]          REG_write_value,
  input  logic                     REG_issue_enable,
  input  logic [$clog2(NUM_REGS)-1:0] REG_issue_address,
  output logic                     REG_stall
);

  localparam int   AW  = $clog2(NUM_REGS);
  localparam logic BYP = (BYPASS != 0);

  logic [XLEN-1:0]     mem [0:NUM_REGS-1];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_RD-1:0]   rd_busy_vec;
  logic                write_ok;
  logic                waw_hazard;
  logic                issue_accept;

  assign write_ok = REG_write_enable && (REG_write_address != AW'(ZERO_REG));

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        mem[i] <= '0;
    end else if (write_ok) begin
      mem[REG_write_address] <= REG_write_value;
    end
  end

  // Outputs are forced quiet while reset is held so decode never sees stale state.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;

    assign addr = REG_rd_addr[k*AW +: AW];
    assign hit  = BYP && write_ok && (addr == REG_write_address);

    assign REG_rd_data[k*XLEN +: XLEN] =
      (SYS_reset || addr == AW'(ZERO_REG)) ? '0 :
      hit                                  ? REG_write_value :
                                             mem[addr];
    assign rd_busy_vec[k] = !SYS_reset && busy[addr] && !hit;
  end

  assign REG_rd_busy = rd_busy_vec;

  assign waw_hazard = busy[REG_issue_address] &&
                      !(BYP && write_ok && REG_write_address == REG_issue_address);

  assign REG_stall = REG_issue_enable && !SYS_reset &&
                     ((|(REG_rd_used & rd_busy_vec)) || waw_hazard);

  assign issue_accept = REG_issue_enable && !REG_stall;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_scoreboard (
    .SYS_clk       (SYS_clk),
    .SYS_reset     (SYS_reset),
    .issue_accept  (issue_accept),
    .issue_address (REG_issue_address),
    .write_enable  (REG_write_enable),
    .write_address (REG_write_address),
    .busy          (busy)
  );

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Scoreboarded bench: three instances (bypass, no bypass, wide 64x16x3) share one clock and reset.
module tb_reg_file_scoreboard;

  logic SYS_clk = 1'b0;
  logic SYS_reset;
  always #5 SYS_clk = ~SYS_clk;

  logic [9:0]  a_rd_addr;  logic [1:0] a_rd_used; logic [63:0] a_rd_data; logic [1:0] a_rd_busy;
  logic        a_we;       logic [4:0] a_wa;      logic [31:0] a_wv;
  logic        a_ie;       logic [4:0] a_ia;      logic        a_stall;

  logic [9:0]  b_rd_addr;  logic [1:0] b_rd_used; logic [63:0] b_rd_data; logic [1:0] b_rd_busy;
  logic        b_we;       logic [4:0] b_wa;      logic [31:0] b_wv;
  logic        b_ie;       logic [4:0] b_ia;      logic        b_stall;

  logic [11:0]  c_rd_addr; logic [2:0] c_rd_used; logic [191:0] c_rd_data; logic [2:0] c_rd_busy;
  logic         c_we;      logic [3:0] c_wa;      logic [63:0]  c_wv;
  logic         c_ie;      logic [3:0] c_ia;      logic         c_stall;

  reg_file_scoreboard #(.XLEN(32), .NUM_REGS(32), .NUM_RD(2), .BYPASS(1)) dut_a (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset),
    .REG_rd_addr(a_rd_addr), .REG_rd_used(a_rd_used), .REG_rd_data(a_rd_data), .REG_rd_busy(a_rd_busy),
    .REG_write_enable(a_we), .REG_write_address(a_wa), .REG_write_value(a_wv),
    .REG_issue_enable(a_ie), .REG_issue_address(a_ia), .REG_stall(a_stall));

  reg_file_scoreboard #(.XLEN(32), .NUM_REGS(32), .NUM_RD(2), .BYPASS(0)) dut_b (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset),
    .REG_rd_addr(b_rd_addr), .REG_rd_used(b_rd_used), .REG_rd_data(b_rd_data), .REG_rd_busy(b_rd_busy),
    .REG_write_enable(b_we), .REG_write_address(b_wa), .REG_write_value(b_wv),
    .REG_issue_enable(b_ie), .REG_issue_address(b_ia), .REG_stall(b_stall));

  reg_file_scoreboard #(.XLEN(64), .NUM_REGS(16), .NUM_RD(3), .BYPASS(1)) dut_c (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset),
    .REG_rd_addr(c_rd_addr), .REG_rd_used(c_rd_used), .REG_rd_data(c_rd_data), .REG_rd_busy(c_rd_busy),
    .REG_write_enable(c_we), .REG_write_address(c_wa), .REG_write_value(c_wv),
    .REG_issue_enable(c_ie), .REG_issue_address(c_ia), .REG_stall(c_stall));

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] e;

  task automatic idle_all();
    a_rd_addr = '0; a_rd_used = '0; a_we = 0; a_wa = '0; a_wv = '0; a_ie = 0; a_ia = '0;
    b_rd_addr = '0; b_rd_used = '0; b_we = 0; b_wa = '0; b_wv = '0; b_ie = 0; b_ia = '0;
    c_rd_addr = '0; c_rd_used = '0; c_we = 0; c_wa = '0; c_wv = '0; c_ie = 0; c_ia = '0;
  endtask

  // Inputs change on the falling edge; comb outputs are sampled 1 time unit later.
  task automatic drive_edge();
    @(negedge SYS_clk);
    idle_all();
  endtask

  task automatic test_x0();
    drive_edge();
    a_we = 1; a_wa = 5'd0; a_wv = 32'h1234; a_ie = 1; a_ia = 5'd0; a_rd_addr = {5'd0, 5'd0}; a_rd_used = 2'b11;
    exp_q.push_back(64'd0); exp_q.push_back(64'd0);
    #1;
    e = exp_q.pop_front(); checks++; if (a_rd_data[31:0] !== e[31:0]) begin errors++; $display("FAIL x0_data got %h want %h", a_rd_data[31:0], e[31:0]); end
    e = exp_q.pop_front(); checks++; if (a_stall !== e[0]) begin errors++; $display("FAIL x0_stall got %b want %b", a_stall, e[0]); end
    drive_edge();
    a_rd_addr = {5'd0, 5'd0}; a_rd_used = 2'b11; a_ie = 1; a_ia = 5'd0;
    exp_q.push_back(64'd0); exp_q.push_back(64'd0); exp_q.push_back(64'd0);
    #1;
    e = exp_q.pop_front(); checks++; if (a_rd_data[31:0] !== e[31:0]) begin errors++; $display("FAIL x0_data_after got %h want %h", a_rd_data[31:0], e[31:0]); end
    e = exp_q.pop_front(); checks++; if (a_rd_busy !== e[1:0]) begin errors++; $display("FAIL x0_busy got %b want %b", a_rd_busy, e[1:0]); end
    e = exp_q.pop_front(); checks++; if (a_stall !== e[0]) begin errors++; $display("FAIL x0_stall_after got %b want %b", a_stall, e[0]); end
  endtask

  task automatic test_raw_bypass();
    drive_edge();
    a_ie = 1; a_ia = 5'd7;
    exp_q.push_back(64'd0);
    #1;
    e = exp_q.pop_front(); checks++; if (a_stall !== e[0]) begin errors++; $display("FAIL raw_issue got %b want %b", a_stall, e[0]); end
    drive_edge();
    a_rd_addr = {5'd10, 5'd7}; a_rd_used = 2'b01; a_ie = 1; a_ia = 5'd10;
    exp_q.push_back(64'd1); exp_q.push_back(64'd1);
    #1;
    e = exp_q.pop_front(); checks++; if (a_rd_busy[0] !== e[0]) begin errors++; $display("FAIL raw_busy got %b want %b", a_rd_busy[0], e[0]); end
    e = exp_q.pop_front(); checks++; if (a_stall !== e[0]) begin errors++; $display("FAIL raw_stall got %b want %b", a_stall, e[0]); end
    drive_edge();
    a_rd_addr = {5'd10, 5'd7}; a_rd_used = 2'b01; a_ie = 1; a_ia = 5'd10;
    a_we = 1; a_wa = 5'd7; a_wv = 32'hA5A5A5A5;
    exp_q.push_back(64'hA5A5A5A5); exp_q.push_back(64'b00); exp_q.push_back(64'd0);
    #1;
    e = exp_q.pop_front(); checks++; if (a_rd_data[31:0] !== e[31:0]) begin errors++; $display("FAIL raw_bypass_data got %h want %h", a_rd_data[31:0], e[31:0]); end
    e = exp_q.pop_front(); checks++; if (a_rd_busy !== e[1:0]) begin errors++; $display("FAIL raw_bypass_busy got %b want %b", a_rd_busy, e[1:0]); end
    e = exp_q.pop_front(); checks++; if (a_stall !== e[0]) begin errors++; $display("FAIL raw_bypass_stall got %b want %b", a_stall, e[0]); end
    drive_edge();
    a_rd_addr = {5'd10, 5'd7};
    exp_q.push_back(64'hA5A5A5A5); exp_q.push_back(64'b10);
    #1;
    e = exp_q.pop_front(); checks++; if (a_rd_data[31:0] !== e[31:0]) begin errors++; $display("FAIL raw_array_data got %h want %h", a_rd_data[31:0], e[31:0]); end
    e = exp_q.pop_front(); checks++; if (a_rd_busy !== e[1:0]) begin errors++; $display("FAIL raw_next_busy got %b want %b", a_rd_busy, e[1:0]); end
    drive_edge();
    a_we = 1; a_wa = 5'd10; a_wv = 32'h10;
  endtask

  task automatic test_raw_no_bypass();
    drive_edge();
    b_ie = 1; b_ia = 5'd7;
    drive_edge();
    b_rd_addr = {5'd0, 5'd7}; b_rd_used = 2'b01; b_ie = 1; b_ia = 5'd10;
    exp_q.push_back(64'd1);
    #1;
    e = exp_q.pop_front(); checks++; if (b_stall !== e[0]) begin errors++; $display("FAIL nb_stall got %b want %b", b_stall, e[0]); end
    drive_edge();
    b_rd_addr = {5'd0, 5'd7}; b_rd_used = 2'b01; b_ie = 1; b_ia = 5'd10;
    b_we = 1; b_wa = 5'd7; b_wv = 32'hA5A5A5A5;
    exp_q.push_back(64'd0); exp_q.push_back(64'd1); exp_q.push_back(64'd1);
    #1;
    e = exp_q.pop_front(); checks++; if (b_rd_data[31:0] !== e[31:0]) begin errors++; $display("FAIL nb_wb_data got %h want %h", b_rd_data[31:0], e[31:0]); end
    e = exp_q.pop_front(); checks++; if (b_rd_busy[0] !== e[0]) begin errors++; $display("FAIL nb_wb_busy got %b want %b", b_rd_busy[0], e[0]); end
    e = exp_q.pop_front(); checks++; if (b_stall !== e[0]) begin errors++; $display("FAIL nb_wb_stall got %b want %b", b_stall, e[0]); end
    drive_edge();
    b_rd_addr = {5'd0, 5'd7}; b_rd_used = 2'b01; b_ie = 1; b_ia = 5'd10;
    exp_q.push_back(64'hA5A5A5A5); exp_q.push_back(64'd0); exp_q.push_back(64'd0);
    #1;
    e = exp_q.pop_front(); checks++; if (b_rd_data[31:0] !== e[31:0]) begin errors++; $display("FAIL nb_after_data got %h want %h", b_rd_data[31:0], e[31:0]); end
    e = exp_q.pop_front(); checks++; if (b_rd_busy[0] !== e[0]) begin errors++; $display("FAIL nb_after_busy got %b want %b", b_rd_busy[0], e[0]); end
    e = exp_q.pop_front(); checks++; if (b_stall !== e[0]) begin errors++; $display("FAIL nb_after_stall got %b want %b", b_stall, e[0]); end
    drive_edge();
    b_we = 1; b_wa = 5'd10; b_wv = 32'h10;
  endtask

  task automatic test_simultaneous();
    drive_edge();
    a_we = 1; a_wa = 5'd9; a_wv = 32'h99; a_ie = 1; a_ia = 5'd9;
    exp_q.push_back(64'd0);
    #1;
    e = exp_q.pop_front(); checks++; if (a_stall !== e[0]) begin errors++; $display("FAIL sim_stall got %b want %b", a_stall, e[0]); end
    for (int i = 0; i < 2; i++) begin
      drive_edge();
      a_rd_addr = {5'd0, 5'd9}; a_rd_used = 2'b01; a_ie = 1; a_ia = 5'd11;
      exp_q.push_back(64'h99); exp_q.push_back(64'd1); exp_q.push_back(64'd1);
      #1;
      e = exp_q.pop_front(); checks++; if (a_rd_data[31:0] !== e[31:0]) begin errors++; $display("FAIL sim_data[%0d] got %h want %h", i, a_rd_data[31:0], e[31:0]); end
      e = exp_q.pop_front(); checks++; if (a_rd_busy[0] !== e[0]) begin errors++; $display("FAIL sim_busy[%0d] got %b want %b", i, a_rd_busy[0], e[0]); end
      e = exp_q.pop_front(); checks++; if (a_stall !== e[0]) begin errors++; $display("FAIL sim_hold[%0d] got %b want %b", i, a_stall, e[0]); end
    end
    drive_edge();
    a_rd_addr = {5'd0, 5'd9}; a_rd_used = 2'b01; a_ie = 1; a_ia = 5'd11;
    a_we = 1; a_wa = 5'd9; a_wv = 32'h1999;
    exp_q.push_back(64'h1999); exp_q.push_back(64'd0);
    #1;
    e = exp_q.pop_front(); checks++; if (a_rd_data[31:0] !== e[31:0]) begin errors++; $display("FAIL sim_wb2_data got %h want %h", a_rd_data[31:0], e[31:0]); end
    e = exp_q.pop_front(); checks++; if (a_stall !== e[0]) begin errors++; $display("FAIL sim_wb2_stall got %b want %b", a_stall, e[0]); end
    drive_edge();
    a_we = 1; a_wa = 5'd11; a_wv = 32'h11;
  endtask

  task automatic test_waw_used();
    drive_edge();
    a_ie = 1; a_ia = 5'd3;
    drive_edge();
    a_ie = 1; a_ia = 5'd3;
    exp_q.push_back(64'd1);
    #1;
    e = exp_q.pop_front(); checks++; if (a_stall !== e[0]) begin errors++; $display("FAIL waw_stall got %b want %b", a_stall, e[0]); end
    drive_edge();
    a_rd_addr = {5'd3, 5'd0}; a_rd_used = 2'b10; a_ie = 1; a_ia = 5'd4;
    exp_q.push_back(64'd1);
    #1;
    e = exp_q.pop_front(); checks++; if (a_stall !== e[0]) begin errors++; $display("FAIL used_stall got %b want %b", a_stall, e[0]); end
    drive_edge();
    a_rd_addr = {5'd3, 5'd0}; a_rd_used = 2'b00; a_ie = 1; a_ia = 5'd4;
    exp_q.push_back(64'd0); exp_q.push_back(64'b10);
    #1;
    e = exp_q.pop_front(); checks++; if (a_stall !== e[0]) begin errors++; $display("FAIL unused_stall got %b want %b", a_stall, e[0]); end
    e = exp_q.pop_front(); checks++; if (a_rd_busy !== e[1:0]) begin errors++; $display("FAIL unused_busy got %b want %b", a_rd_busy, e[1:0]); end
    drive_edge();
    a_ie = 1; a_ia = 5'd3; a_we = 1; a_wa = 5'd3; a_wv = 32'h33;
    exp_q.push_back(64'd0);
    #1;
    e = exp_q.pop_front(); checks++; if (a_stall !== e[0]) begin errors++; $display("FAIL waw_cleared_stall got %b want %b", a_stall, e[0]); end
    drive_edge();
    a_rd_addr = {5'd3, 5'd4};
    exp_q.push_back(64'b11); exp_q.push_back(64'h33);
    #1;
    e = exp_q.pop_front(); checks++; if (a_rd_busy !== e[1:0]) begin errors++; $display("FAIL waw_busy_after got %b want %b", a_rd_busy, e[1:0]); end
    e = exp_q.pop_front(); checks++; if (a_rd_data[63:32] !== e[31:0]) begin errors++; $display("FAIL waw_data got %h want %h", a_rd_data[63:32], e[31:0]); end
  endtask

  task automatic test_reset();
    drive_edge();
    a_we = 1; a_wa = 5'd5; a_wv = 32'h55;
    drive_edge();
    SYS_reset = 1;
    a_we = 1; a_wa = 5'd5; a_wv = 32'hDEADBEEF; a_ie = 1; a_ia = 5'd6;
    a_rd_addr = {5'd3, 5'd5}; a_rd_used = 2'b11;
    exp_q.push_back(64'd0); exp_q.push_back(64'b00); exp_q.push_back(64'd0);
    #1;
    e = exp_q.pop_front(); checks++; if (a_rd_data[31:0] !== e[31:0]) begin errors++; $display("FAIL rst_data got %h want %h", a_rd_data[31:0], e[31:0]); end
    e = exp_q.pop_front(); checks++; if (a_rd_busy !== e[1:0]) begin errors++; $display("FAIL rst_busy got %b want %b", a_rd_busy, e[1:0]); end
    e = exp_q.pop_front(); checks++; if (a_stall !== e[0]) begin errors++; $display("FAIL rst_stall got %b want %b", a_stall, e[0]); end
    drive_edge();
    SYS_reset = 0;
    a_rd_addr = {5'd6, 5'd5};
    exp_q.push_back(64'd0); exp_q.push_back(64'b00);
    #1;
    e = exp_q.pop_front(); checks++; if (a_rd_data[31:0] !== e[31:0]) begin errors++; $display("FAIL post_rst_x5 got %h want %h", a_rd_data[31:0], e[31:0]); end
    e = exp_q.pop_front(); checks++; if (a_rd_busy !== e[1:0]) begin errors++; $display("FAIL post_rst_busy got %b want %b", a_rd_busy, e[1:0]); end
    drive_edge();
    a_rd_addr = {5'd4, 5'd3}; a_we = 1; a_wa = 5'd3; a_wv = 32'h77;
    exp_q.push_back(64'b00);
    #1;
    e = exp_q.pop_front(); checks++; if (a_rd_busy !== e[1:0]) begin errors++; $display("FAIL post_rst_dropped got %b want %b", a_rd_busy, e[1:0]); end
    drive_edge();
    a_rd_addr = {5'd0, 5'd3};
    exp_q.push_back(64'h77);
    #1;
    e = exp_q.pop_front(); checks++; if (a_rd_data[31:0] !== e[31:0]) begin errors++; $display("FAIL post_rst_write got %h want %h", a_rd_data[31:0], e[31:0]); end
  endtask

  task automatic test_wide();
    drive_edge();
    c_we = 1; c_wa = 4'd15; c_wv = 64'hFFFF_0000_FFFF_0000;
    drive_edge();
    c_rd_addr = {4'd15, 4'd15, 4'd15};
    for (int k = 0; k < 3; k++) exp_q.push_back(64'hFFFF_0000_FFFF_0000);
    #1;
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front(); checks++;
      if (c_rd_data[k*64 +: 64] !== e) begin errors++; $display("FAIL wide_x15[%0d] got %h want %h", k, c_rd_data[k*64 +: 64], e); end
    end
    drive_edge();
    c_rd_addr = {4'd0, 4'd0, 4'd0};
    for (int k = 0; k < 3; k++) exp_q.push_back(64'd0);
    #1;
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front(); checks++;
      if (c_rd_data[k*64 +: 64] !== e) begin errors++; $display("FAIL wide_x0[%0d] got %h want %h", k, c_rd_data[k*64 +: 64], e); end
    end
    exp_q.push_back(64'd0);
    e = exp_q.pop_front(); checks++;
    if (c_rd_busy !== e[2:0]) begin errors++; $display("FAIL wide_busy got %b want %b", c_rd_busy, e[2:0]); end
  endtask

  initial begin
    idle_all();
    SYS_reset = 1;
    repeat (2) @(negedge SYS_clk);
    SYS_reset = 0;
    test_x0();
    test_raw_bypass();
    test_raw_no_bypass();
    test_simultaneous();
    test_waw_used();
    test_reset();
    test_wide();
    drive_edge();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
